// File: rtl/aes_key_sched_ctrl_if.sv
// Bundle of key-load handshake, expander control and round-key read signals
// shared between the key schedule controller and its surroundings.
interface aes_key_sched_ctrl_if;
   logic [127:0] key_in;
   logic         key_valid;
   logic         key_ready;
   logic         kx_start_pos;
   logic         kx_key_update;
   logic [7:0]   kx_rcon;
   logic [127:0] kx_in;
   logic [127:0] kx_out;
   logic         keys_valid;
   logic         rk_rd;
   logic [3:0]   rk_addr;
   logic [127:0] rk_data;
   logic         rk_rvalid;
   logic         rk_err;

   // key source / expander / round engine side
   modport master (
      output key_in, key_valid, kx_out, rk_rd, rk_addr,
      input  key_ready, kx_start_pos, kx_key_update, kx_rcon, kx_in,
             keys_valid, rk_data, rk_rvalid, rk_err
   );

   // controller side
   modport slave (
      input  key_in, key_valid, kx_out, rk_rd, rk_addr,
      output key_ready, kx_start_pos, kx_key_update, kx_rcon, kx_in,
             keys_valid, rk_data, rk_rvalid, rk_err
   );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule sequencer and 11-entry round-key store.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no key yet, ready for a key
// LOAD   | expander loads the latched key (round key 0)
// EXPAND | 10 cycles: store round key r-1, step expander with rcon(r)
// LAST   | store round key 10, expander held
// DONE   | all round keys readable, ready for a new key
module aes_key_sched_ctrl (
   input logic                 clk,
   input logic                 rst_n,
   aes_key_sched_ctrl_if.slave ks_if
);

   typedef enum logic [2:0] {IDLE, LOAD, EXPAND, LAST, DONE} state_t;

   state_t       state_q, state_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [127:0] key_q, key_d;
   logic         keys_valid_q, keys_valid_d;
   logic [127:0] rk_data_q;
   logic         rk_rvalid_q, rk_err_q;
   logic [127:0] store_q [0:10];
   logic         st_we;
   logic [3:0]   st_idx;
   logic         rd_ok;

   // State and sequencing registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rnd_q        <= 4'd0;
         rcon_q       <= 8'h01;
         key_q        <= '0;
         keys_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rnd_q        <= rnd_d;
         rcon_q       <= rcon_d;
         key_q        <= key_d;
         keys_valid_q <= keys_valid_d;
      end
   end

   // Next-state logic and state-decoded expander controls
   always_comb begin
      state_d             = state_q;
      rnd_d               = rnd_q;
      rcon_d              = rcon_q;
      key_d               = key_q;
      keys_valid_d        = keys_valid_q;
      st_we               = 1'b0;
      st_idx              = 4'd0;
      ks_if.key_ready     = 1'b0;
      ks_if.kx_start_pos  = 1'b0;
      ks_if.kx_key_update = 1'b0;
      ks_if.kx_rcon       = 8'h00;
      case (state_q)
         IDLE, DONE: begin
            ks_if.key_ready = 1'b1;
            if (ks_if.key_valid) begin
               key_d        = ks_if.key_in;
               keys_valid_d = 1'b0;
               state_d      = LOAD;
            end
         end
         LOAD: begin
            ks_if.kx_start_pos  = 1'b1;
            ks_if.kx_key_update = 1'b1;
            rnd_d               = 4'd1;
            rcon_d              = 8'h01;
            state_d             = EXPAND;
         end
         EXPAND: begin
            ks_if.kx_key_update = 1'b1;
            ks_if.kx_rcon       = rcon_q;
            st_we               = 1'b1;
            st_idx              = rnd_q - 4'd1;
            // xtime: multiply by x in GF(2^8)
            rcon_d              = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            rnd_d               = rnd_q + 4'd1;
            if (rnd_q == 4'd10) state_d = LAST;
         end
         LAST: begin
            st_we        = 1'b1;
            st_idx       = 4'd10;
            keys_valid_d = 1'b1;
            rnd_d        = 4'd0;
            state_d      = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Round-key store; contents are only meaningful once keys_valid is set
   always_ff @(posedge clk) begin
      if (st_we) store_q[st_idx] <= ks_io_kx_out();
   end

   function automatic logic [127:0] ks_io_kx_out();
      return ks_if.kx_out;
   endfunction

   // Read port: one request per cycle, answered the next cycle
   assign rd_ok = ks_if.rk_rd && keys_valid_q && (ks_if.rk_addr <= 4'd10);

   // Registered read data with valid / refusal pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rk_data_q   <= '0;
         rk_rvalid_q <= 1'b0;
         rk_err_q    <= 1'b0;
      end else begin
         rk_rvalid_q <= rd_ok;
         rk_err_q    <= ks_if.rk_rd && !rd_ok;
         if (rd_ok) rk_data_q <= store_q[ks_if.rk_addr];
      end
   end

   assign ks_if.kx_in      = key_q;
   assign ks_if.keys_valid = keys_valid_q;
   assign ks_if.rk_data    = rk_data_q;
   assign ks_if.rk_rvalid  = rk_rvalid_q;
   assign ks_if.rk_err     = rk_err_q;

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequencer and round-key store for the AES-128 key expander. It accepts a 128-bit cipher key over a valid/ready handshake and drives the expander's load, update and rcon controls through 10 expansion rounds. It captures all 11 round keys into an internal store and serves them by index to the encrypt/decrypt round engine, so decryption can read keys in reverse order.

## Interface
Parameters: none; AES-128 only (Nr = 10, 11 round keys).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- key_in  in  128  cipher key, word 0 in bits [127:96]
- key_valid  in  1  key_in valid
- key_ready  out  1  controller can accept a key
- kx_start_pos  out  1  expander: load key_in instead of the next round
- kx_key_update  out  1  expander register enable
- kx_rcon  out  8  expander round constant
- kx_in  out  128  expander load data; the latched key
- kx_out  in  128  expander current round key (registered in expander)
- keys_valid  out  1  all 11 round keys stored and readable
- rk_rd  in  1  round-key read request
- rk_addr  in  4  round index 0..10
- rk_data  out  128  round key, registered
- rk_rvalid  out  1  rk_data valid, one-cycle pulse
- rk_err  out  1  read refused, one-cycle pulse

## Operation
- States: IDLE, LOAD, EXPAND, LAST, DONE. Reset enters IDLE.
- key_ready is 1 in IDLE and DONE, and 0 otherwise. It is decoded from state, so it is 1 during reset.
- Handshake: key_valid & key_ready at an edge latches key_in, clears keys_valid and moves to LOAD.
- LOAD, one cycle: kx_start_pos=1, kx_key_update=1, kx_in=latched key.
- EXPAND, 10 cycles, round counter r=1..10:
  - Write kx_out (round key r-1) to store[r-1].
  - Drive kx_key_update=1, kx_start_pos=0, kx_rcon=rcon(r).
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36. It is held in a register that starts at 01 and advances by xtime: shift left 1, XOR 0x1B if bit 7 was set.
- LAST, one cycle: write kx_out (round key 10) to store[10], with kx_key_update=0. Next state is DONE with keys_valid=1.
- DONE: hold until a new key handshake, which moves to LOAD.
- key_valid during LOAD/EXPAND/LAST is ignored because key_ready=0. Key_in is not re-sampled.
- kx_* outputs are decoded from state. In IDLE and DONE: kx_key_update=0, kx_start_pos=0, kx_rcon=00.
- Reads are accepted in any state:
  - rk_rd with keys_valid=1 and rk_addr<=10 returns store[rk_addr] on rk_data with rk_rvalid=1 the next cycle.
  - rk_rd with keys_valid=0, or with rk_addr 11..15, gives rk_err=1 and rk_rvalid=0 the next cycle. rk_data holds its previous value.
  - A read in the same cycle as a key handshake is evaluated with the pre-edge keys_valid, so it still returns the old key.

## Timing
- Reset values: state IDLE, keys_valid=0, rk_data=0, rk_rvalid=0, rk_err=0, rcon register=01, round counter=0, latched key=0. Store contents are not reset and are unreadable until keys_valid=1.
- Handshake at edge T:
  - LOAD during cycle T+1.
  - EXPAND during cycles T+2..T+11.
  - LAST during cycle T+12.
  - keys_valid=1 from T+13; latency is 13 cycles.
- Back-to-back: a handshake in DONE drops keys_valid at the next edge. The same 13-cycle sequence then follows.
- Read latency is 1 cycle. One read per cycle, fully pipelined; rk_rd may be asserted every cycle.
- Reset asserted mid-sequence: immediately returns to IDLE with keys_valid=0. The expander is reloaded by the next LOAD.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - keys_valid rises exactly 13 cycles after the handshake.
  - rk_addr=1 returns a0fafe1788542cb123a339392a6c7605.
  - rk_addr=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk_addr=0 returns the key itself.
- Monitor kx_rcon during EXPAND: exactly 01,02,04,08,10,20,40,80,1B,36 on consecutive cycles with kx_key_update=1. kx_start_pos=1 only in the single LOAD cycle.
- Reads with keys_valid=0, and rk_addr=11 or 15 in DONE: rk_err pulses next cycle, rk_rvalid=0, rk_data unchanged.
- Read rk_addr=10..0, one per cycle, in DONE: 11 consecutive rk_rvalid pulses with keys in reverse order.
- Second key 000102030405060708090a0b0c0d0e0f accepted in DONE:
  - key_ready=0 and key_valid is ignored during the sequence.
  - keys_valid drops, then rises 13 cycles later.
  - rk_addr=10 returns 13111d7fe3944a17f307a78b4d2b30c5.
- Assert rst_n low at cycle T+6 of a sequence: all outputs go to reset values asynchronously. After release, a fresh key completes normally with correct keys.
